restador: RTL and testbench
===========================

# restador

Registered two's-complement/unsigned subtractor: the arithmetic inverse of the team's adder, speaking the same `valid`/`ack` stream handshake on both sides. Computes `a - b` with difference, borrow-out and signed overflow flags. A 2-entry result buffer sustains one operation per cycle under back-pressure and removes any combinational path from `output_ack` to `input_ack`. Drops in directly downstream of, or in parallel with, the adder in the arithmetic test datapaths.

## Interface
- `WIDTH`, 3, operand and difference width in bits (≥2)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `a`  in  WIDTH  minuend
- `b`  in  WIDTH  subtrahend
- `input_valid`  in  1  `a`/`b` valid
- `input_ack`  out  1  operands accepted this cycle
- `diff`  out  WIDTH  `(a - b) mod 2^WIDTH`
- `overflow`  out  1  signed result out of range
- `borrow_out`  out  1  unsigned `a < b`
- `output_valid`  out  1  result presented
- `output_ack`  in  1  downstream accepts result

## Operation
- Input handshake `in_hs = input_valid & input_ack`; output handshake `out_hs = output_valid & output_ack`.
- `input_ack = input_valid & (count != 2) & ~rst`; `count` is registered occupancy, 0..2. Ack never asserted without valid (same convention as the adder).
- Arithmetic on `in_hs`, computed at WIDTH+1 bits: `aux = {1'b0,a} - {1'b0,b}`; `diff = aux[WIDTH-1:0]`; `borrow_out = aux[WIDTH]`; `overflow = (a[W-1] != b[W-1]) & (diff[W-1] != a[W-1])`.
- Result `{overflow, borrow_out, diff}` written to buffer tail; head drives outputs.
- Occupancy: `in_hs & ~out_hs` → +1; `out_hs & ~in_hs` → −1; both → unchanged (head advances, new entry to tail).
- `output_valid = (count != 0)`, registered.
- Results emerge in acceptance order; none dropped or duplicated.

## Timing
- Reset: `count=0`, `output_valid=0`, `diff=0`, `overflow=0`, `borrow_out=0`; `input_ack=0` while `rst` high. Reset mid-operation discards all buffered results; the cycle after reset deassertion, `input_ack` follows `input_valid`.
- Latency: `in_hs` at edge N → `output_valid=1` with result after edge N (visible cycle N+1) when buffer empty.
- Throughput: one result/cycle while `output_ack` held high.
- Stall: while `output_valid & ~output_ack`, `diff`, `overflow`, `borrow_out` stable.
- Full (`count=2`): `input_ack=0` even if `out_hs` this cycle; acceptance resumes next cycle (one-cycle bubble accepted by design).
- Empty: `output_ack` ignored, no state change.
- `input_ack` depends only on `input_valid`, `rst` and registers; no path from `output_ack`.

## Structure
- Shared constants header: result record width `WIDTH+2` and field offsets (`DIFF_LSB=0`, `BORROW_BIT=WIDTH`, `OVF_BIT=WIDTH+1`), reused by the adder test wrappers.
- One sub-module: `skid_buffer` — generic 2-entry FIFO, parameter `DATA_W`, ports `push/din/full`, `pop/dout/valid`, sync active-high reset. `restador` = subtract/flag logic + `skid_buffer` with `DATA_W=WIDTH+2`.
- Waveform dump under `COCOTB_SIM` as in other blocks.

## Test plan
- Reset then `a=3,b=3` valid, `output_ack=1` → next cycle `diff=0`, `borrow_out=0`, `overflow=0`, `output_valid=1`; then `output_valid=0`.
- `a=2,b=5` → `diff=5`, `borrow_out=1`, `overflow=1`; `a=5,b=2` → `diff=3`, `borrow_out=0`, `overflow=1`; `a=0,b=1` → `diff=7`, `borrow_out=1`, `overflow=0`.
- `output_ack=0`, three back-to-back valid operands (1-0, 2-0, 3-0) → first two acked, third held with `input_ack=0`; outputs stable at `diff=1`; release ack → 1,2,3 in order, third accepted cycle after first pop.
- `output_ack=1`, `input_valid` high 8 cycles, sweeping `a=0..7`, `b=4` → 8 acks, 8 results, `count` never exceeds 1.
- `rst` pulsed with `count=2` → `output_valid=0`, all outputs 0 next cycle; buffered results never appear.
- Random valid/ack for 10k ops, `WIDTH=3` and `WIDTH=8`, vs Python model → exact stream match, `input_ack` never high with `input_valid` low.

Source files
------------

// File: rtl/restador_pkg.sv
// Shared result-record layout for the subtractor and the adder test wrappers:
// {overflow, borrow_out, diff} packed LSB-first.
package restador_pkg;

  localparam int DIFF_LSB = 0;

  function automatic int rec_w(input int width);
    return width + 2;
  endfunction

  function automatic int borrow_bit(input int width);
    return width;
  endfunction

  function automatic int ovf_bit(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry FIFO that lets the producer and the consumer handshake independently.
// Pops on an empty buffer and pushes into a full one are ignored.
module skid_buffer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              valid
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              r_valid;

  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_count_nxt;

  assign w_push = push & (r_count != 2'd2);
  assign w_pop  = pop & (r_count != 2'd0);

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is reset too, so the outputs read as zero after reset rather than stale data.
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != 2'd0);
    end
  end

  assign full  = (r_count == 2'd2);
  assign dout  = r_mem[r_rd_ptr];
  assign valid = r_valid;

endmodule

// File: rtl/restador.sv
// Registered subtractor a - b with borrow and signed-overflow flags behind a valid/ack
// stream handshake; a 2-entry buffer keeps output_ack off the input_ack path.
module restador
  import restador_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             input_valid,
  output logic             input_ack,
  output logic [WIDTH-1:0] diff,
  output logic             overflow,
  output logic             borrow_out,
  output logic             output_valid,
  input  logic             output_ack
);

  localparam int REC_W   = rec_w(WIDTH);
  localparam int BRW_BIT = borrow_bit(WIDTH);
  localparam int OVF_BIT = ovf_bit(WIDTH);

  logic [WIDTH:0]   w_aux;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic             w_ovf;
  logic [REC_W-1:0] w_rec;
  logic [REC_W-1:0] w_head;
  logic             w_full;

  // The extra MSB of the widened difference is the unsigned borrow.
  assign w_aux    = {1'b0, a} - {1'b0, b};
  assign w_diff   = w_aux[WIDTH-1:0];
  assign w_borrow = w_aux[WIDTH];
  assign w_ovf    = (a[WIDTH-1] != b[WIDTH-1]) & (w_diff[WIDTH-1] != a[WIDTH-1]);
  assign w_rec    = {w_ovf, w_borrow, w_diff};

  // Full blocks acceptance even when a pop happens this cycle, keeping output_ack out of this term.
  assign input_ack = input_valid & ~w_full & ~rst;

  skid_buffer #(
    .DATA_W (REC_W)
  ) u_skid_buffer (
    .clk   (clk),
    .rst   (rst),
    .push  (input_ack),
    .din   (w_rec),
    .full  (w_full),
    .pop   (output_ack),
    .dout  (w_head),
    .valid (output_valid)
  );

  assign diff       = w_head[DIFF_LSB +: WIDTH];
  assign borrow_out = w_head[BRW_BIT];
  assign overflow   = w_head[OVF_BIT];

endmodule

// File: tb/tb_restador.sv
// Directed checks for restador at WIDTH=3: vector table, stall/back-pressure, sweep,
// reset-while-full, and a short randomized run against an occupancy/queue model.
module tb_restador;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         input_valid;
  logic         input_ack;
  logic [W-1:0] diff;
  logic         overflow;
  logic         borrow_out;
  logic         output_valid;
  logic         output_ack;

  restador #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .a            (a),
    .b            (b),
    .input_valid  (input_valid),
    .input_ack    (input_ack),
    .diff         (diff),
    .overflow     (overflow),
    .borrow_out   (borrow_out),
    .output_valid (output_valid),
    .output_ack   (output_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent reference: signed range test instead of sign-bit comparison.
  function automatic logic [W+1:0] model(input int ai, input int bi);
    int sa, sb, s;
    logic ov, bo;
    logic [W-1:0] d;
    sa = (ai >= 4) ? ai - 8 : ai;
    sb = (bi >= 4) ? bi - 8 : bi;
    s  = sa - sb;
    ov = (s < -4) || (s > 3);
    bo = (ai < bi);
    d  = W'((ai - bi) & 7);
    return {ov, bo, d};
  endfunction

  task automatic drive(input logic v, input int ai, input int bi, input logic ack);
    input_valid = v;
    a           = W'(ai);
    b           = W'(bi);
    output_ack  = ack;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[11];
    logic [W+1:0] q[$];
    int m_cnt;
    logic exp_ack;

    vecs[0]  = '{a: 3'd3, b: 3'd3, d: 3'd0, bo: 1'b0, ov: 1'b0};
    vecs[1]  = '{a: 3'd2, b: 3'd5, d: 3'd5, bo: 1'b1, ov: 1'b1};
    vecs[2]  = '{a: 3'd5, b: 3'd2, d: 3'd3, bo: 1'b0, ov: 1'b1};
    vecs[3]  = '{a: 3'd0, b: 3'd1, d: 3'd7, bo: 1'b1, ov: 1'b0};
    vecs[4]  = '{a: 3'd7, b: 3'd7, d: 3'd0, bo: 1'b0, ov: 1'b0};
    vecs[5]  = '{a: 3'd4, b: 3'd1, d: 3'd3, bo: 1'b0, ov: 1'b1};
    vecs[6]  = '{a: 3'd0, b: 3'd4, d: 3'd4, bo: 1'b1, ov: 1'b1};
    vecs[7]  = '{a: 3'd6, b: 3'd3, d: 3'd3, bo: 1'b0, ov: 1'b1};
    vecs[8]  = '{a: 3'd3, b: 3'd7, d: 3'd4, bo: 1'b1, ov: 1'b1};
    vecs[9]  = '{a: 3'd1, b: 3'd2, d: 3'd7, bo: 1'b1, ov: 1'b0};
    vecs[10] = '{a: 3'd7, b: 3'd0, d: 3'd7, bo: 1'b0, ov: 1'b0};

    rst = 1'b1;
    input_valid = 1'b0;
    a = '0;
    b = '0;
    output_ack = 1'b0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    input_valid = 1'b1;
    #1;
    check("ack_in_reset", 32'(input_ack), 0);
    check("reset_ovalid", 32'(output_valid), 0);
    check("reset_diff", 32'(diff), 0);
    check("reset_flags", 32'({overflow, borrow_out}), 0);
    do_reset();

    // Single operations, one at a time, output_ack high
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(1'b1, int'(vecs[i].a), int'(vecs[i].b), 1'b1);
      check($sformatf("vec%0d_ack", i), 32'(input_ack), 1);
      @(negedge clk);
      drive(1'b0, 0, 0, 1'b1);
      check($sformatf("vec%0d_ovalid", i), 32'(output_valid), 1);
      check($sformatf("vec%0d_diff", i), 32'(diff), 32'(vecs[i].d));
      check($sformatf("vec%0d_borrow", i), 32'(borrow_out), 32'(vecs[i].bo));
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ov));
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_drain", i), 32'(output_valid), 0);
    end

    // Back-pressure: 1-0, 2-0, 3-0 with output_ack low
    @(negedge clk);
    drive(1'b1, 1, 0, 1'b0);
    check("stall_ack1", 32'(input_ack), 1);
    @(negedge clk);
    drive(1'b1, 2, 0, 1'b0);
    check("stall_ack2", 32'(input_ack), 1);
    check("stall_head1", 32'(diff), 1);
    @(negedge clk);
    drive(1'b1, 3, 0, 1'b0);
    check("stall_full_ack", 32'(input_ack), 0);
    check("stall_hold_diff", 32'(diff), 1);
    @(negedge clk);
    drive(1'b1, 3, 0, 1'b0);
    check("stall_full_ack2", 32'(input_ack), 0);
    check("stall_hold_diff2", 32'(diff), 1);
    check("stall_hold_ovalid", 32'(output_valid), 1);
    @(negedge clk);
    drive(1'b1, 3, 0, 1'b1);
    check("full_pop_no_ack", 32'(input_ack), 0);
    check("release_out1", 32'(diff), 1);
    @(negedge clk);
    drive(1'b1, 3, 0, 1'b1);
    check("resume_ack", 32'(input_ack), 1);
    check("release_out2", 32'(diff), 2);
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b1);
    check("release_ovalid3", 32'(output_valid), 1);
    check("release_out3", 32'(diff), 3);
    @(negedge clk);
    #1;
    check("release_empty", 32'(output_valid), 0);

    // Streaming sweep a=0..7, b=4 with output_ack high
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, i, 4, 1'b1);
      check($sformatf("sweep%0d_ack", i), 32'(input_ack), 1);
      if (i > 0) begin
        check($sformatf("sweep%0d_ovalid", i - 1), 32'(output_valid), 1);
        check($sformatf("sweep%0d_res", i - 1), 32'({overflow, borrow_out, diff}), 32'(model(i - 1, 4)));
      end
    end
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b1);
    check("sweep7_res", 32'({overflow, borrow_out, diff}), 32'(model(7, 4)));
    @(negedge clk);
    #1;
    check("sweep_empty", 32'(output_valid), 0);

    // Reset while full discards buffered results
    @(negedge clk);
    drive(1'b1, 6, 1, 1'b0);
    @(negedge clk);
    drive(1'b1, 5, 1, 1'b0);
    @(negedge clk);
    drive(1'b1, 4, 1, 1'b0);
    check("prefull_ack", 32'(input_ack), 0);
    rst = 1'b1;
    #1;
    check("rst_mid_ack", 32'(input_ack), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 0, 0, 1'b1);
    check("rst_mid_ovalid", 32'(output_valid), 0);
    check("rst_mid_outs", 32'({overflow, borrow_out, diff}), 0);
    check("no_ack_without_valid", 32'(input_ack), 0);
    @(negedge clk);
    #1;
    check("rst_no_ghost", 32'(output_valid), 0);
    drive(1'b1, 2, 1, 1'b1);
    check("post_rst_ack", 32'(input_ack), 1);
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b1);
    check("post_rst_res", 32'({overflow, borrow_out, diff}), 32'(model(2, 1)));
    @(negedge clk);
    #1;

    // Randomized valid/ack against an occupancy + queue model
    do_reset();
    m_cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int ra, rb;
      logic rv, rk;
      @(negedge clk);
      ra = int'($urandom_range(0, 7));
      rb = int'($urandom_range(0, 7));
      rv = 1'($urandom_range(0, 1));
      rk = 1'($urandom_range(0, 2) != 0);
      drive(rv, ra, rb, rk);
      exp_ack = rv && (m_cnt != 2);
      check("rand_ack", 32'(input_ack), 32'(exp_ack));
      check("rand_ovalid", 32'(output_valid), 32'(m_cnt != 0));
      if (m_cnt != 0) begin
        check("rand_res", 32'({overflow, borrow_out, diff}), 32'(q[0]));
      end
      if (rk && m_cnt != 0) begin
        void'(q.pop_front());
      end
      if (exp_ack) begin
        q.push_back(model(ra, rb));
      end
      m_cnt = q.size();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
